// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, default operand width and small op-decode helpers.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mduOp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mduState_e;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate; with
// negate tied to the sign bit it doubles as an absolute-value stage.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] dataIn,
  input  logic         negate,
  output logic [W-1:0] dataOut
);

  assign dataOut = negate ? (~dataIn + W'(1)) : dataIn;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle.
// Optional macro MDU_FLUSH_EN enables ctl_flush to cancel an in-flight op.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_start,
  input  logic [1:0]       ctl_op,
  input  logic [WIDTH-1:0] reg_readData0,
  input  logic [WIDTH-1:0] reg_readData1,
  input  logic             ctl_flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mduState_e          state, stateNext;
  mduOp_e             opReg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, accNext;
  logic [WIDTH-1:0]   opnd;
  logic               negProd, negRem, divZeroReg;

  logic               flushReq, startAccept, inSigned, inDiv, inDivZero;
  logic               isDiv, lastIter, divFits;
  logic [WIDTH-1:0]   absRs, absRt, remFixed, remDiff, newRem;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH:0]     mulSum, remShift;

`ifdef MDU_FLUSH_EN
  assign flushReq = ctl_flush;
`else
  logic unusedFlush;
  assign unusedFlush = ctl_flush;
  assign flushReq    = 1'b0;
`endif

  assign inSigned    = isSignedOp(ctl_op);
  assign inDiv       = isDivOp(ctl_op);
  assign inDivZero   = inDiv && (reg_readData1 == '0);
  assign startAccept = ctl_start && (state == IDLE) && !flushReq;
  assign isDiv       = isDivOp(opReg);
  assign lastIter    = (cnt == CNT_W'(WIDTH - 1));
  assign busy        = (state != IDLE);

  mdu_sign_fix #(.W(WIDTH)) uAbsRs (
    .dataIn (reg_readData0),
    .negate (inSigned && reg_readData0[WIDTH-1]),
    .dataOut(absRs)
  );

  mdu_sign_fix #(.W(WIDTH)) uAbsRt (
    .dataIn (reg_readData1),
    .negate (inSigned && reg_readData1[WIDTH-1]),
    .dataOut(absRt)
  );

  // Low half of a 2*WIDTH negate equals the WIDTH-bit negate, so this one
  // instance serves both the full product and the quotient.
  mdu_sign_fix #(.W(2*WIDTH)) uFixProd (
    .dataIn (acc),
    .negate (negProd),
    .dataOut(prodFixed)
  );

  mdu_sign_fix #(.W(WIDTH)) uFixRem (
    .dataIn (acc[2*WIDTH-1:WIDTH]),
    .negate (negRem),
    .dataOut(remFixed)
  );

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divFits  = (remShift >= {1'b0, opnd});
    remDiff  = remShift[WIDTH-1:0] - opnd;
    newRem   = divFits ? remDiff : remShift[WIDTH-1:0];
    accNext  = isDiv ? {newRem, acc[WIDTH-2:0], divFits}
                     : {mulSum, acc[WIDTH-1:1]};
  end

  always_comb begin
    // NOTE: defaulting stateNext before the case keeps every path assigned,
    // so no latch is inferred when a branch leaves the state unchanged.
    stateNext = state;
    unique case (state)
      IDLE:    if (startAccept) stateNext = inDivZero ? FIXUP : CALC;
      CALC:    if (flushReq) stateNext = IDLE;
               else if (lastIter) stateNext = FIXUP;
      FIXUP:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opReg      <= OP_MULT;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      negProd    <= 1'b0;
      negRem     <= 1'b0;
      divZeroReg <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state <= stateNext;
      done  <= 1'b0;
      unique case (state)
        IDLE: if (startAccept) begin
          opReg      <= mduOp_e'(ctl_op);
          cnt        <= '0;
          div_zero   <= 1'b0;
          divZeroReg <= inDivZero;
          negProd    <= inSigned && (reg_readData0[WIDTH-1] ^ reg_readData1[WIDTH-1]);
          negRem     <= inSigned && reg_readData0[WIDTH-1];
          opnd       <= inDiv ? absRt : absRs;
          // Divide-by-zero parks raw rs in the upper half for HI.
          acc        <= inDivZero ? {reg_readData0, {WIDTH{1'b0}}}
                      : {{WIDTH{1'b0}}, (inDiv ? absRs : absRt)};
        end
        CALC: if (!flushReq) begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
        end
        FIXUP: if (!flushReq) begin
          done <= 1'b1;
          if (divZeroReg) begin
            hi       <= acc[2*WIDTH-1:WIDTH];
            lo       <= '1;
            div_zero <= 1'b1;
          end else if (isDiv) begin
            hi <= remFixed;
            lo <= prodFixed[WIDTH-1:0];
          end else begin
            hi <= prodFixed[2*WIDTH-1:WIDTH];
            lo <= prodFixed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// ops compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, ctl_start, ctl_flush;
  logic [1:0]  ctl_op;
  logic [31:0] rs, rt;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expHi = '0, expLo = '0;

  mult_div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ctl_start    (ctl_start),
    .ctl_op       (ctl_op),
    .reg_readData0(rs),
    .reg_readData1(rt),
    .ctl_flush    (ctl_flush),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // HI/LO as the ISA defines them, using native 64-bit and 32-bit arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint          sp;
    longint unsigned up;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          l  = 32'hFFFF_FFFF;
          h  = a;
        end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'h0;
        end else if (op == 2'd2) begin
          l = $signed(a) / $signed(b);
          h = $signed(a) % $signed(b);
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Starts an op at the current negedge (unit idle or in its done cycle)
  // and returns at the negedge where done is seen.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int glitchAt, input int flushAt);
    logic [31:0] eh, el;
    logic        ed;
    int          lat, expLat;
    refModel(op, a, b, eh, el, ed);
    expLat    = (op[1] && b == 0) ? 1 : 33;
    ctl_start = 1'b1;
    ctl_op    = op;
    rs        = a;
    rt        = b;
    @(negedge clk);
    ctl_start = 1'b0;
    ctl_op    = 2'($urandom);
    rs        = $urandom;
    rt        = $urandom;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    check("div_zero_cleared_at_start", div_zero, 0);
    check("hi_hold", hi, expHi);
    check("lo_hold", lo, expLo);
    lat = 0;
    while (!done && lat < 60) begin
      ctl_start = (lat == glitchAt);
      ctl_flush = (lat == flushAt);
      if (lat == glitchAt) begin
        ctl_op = 2'($urandom);
        rs     = $urandom;
        rt     = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    ctl_start = 1'b0;
    ctl_flush = 1'b0;
    check("latency", lat, expLat);
    check("busy_at_done", busy, 0);
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    check("div_zero_result", div_zero, ed);
    expHi = eh;
    expLo = el;
  endtask

  initial begin
    int nDone;
    reset     = 1'b1;
    ctl_start = 1'b0;
    ctl_flush = 1'b0;
    ctl_op    = 2'd0;
    rs        = '0;
    rt        = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back from each done cycle.
    runOp(2'd0, 32'hFFFF_FFFD, 32'd7, -1, -1);
    runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    runOp(2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
    runOp(2'd3, 32'd100, 32'd7, -1, -1);
    runOp(2'd3, 32'h0000_1234, 32'd0, -1, -1);
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    runOp(2'd2, 32'hFFFF_FFF0, 32'd0, -1, -1);
    runOp(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1);
    runOp(2'd0, 32'h8000_0000, 32'h8000_0000, -1, -1);

    for (int i = 0; i < 24; i++) begin
      runOp(2'($urandom), pick(), pick(), -1, -1);
    end

    // Establish HI/LO = 5/6 before the flush scenario.
    runOp(2'd3, 32'd47, 32'd7, -1, -1);
`ifdef MDU_FLUSH_EN
    ctl_start = 1'b1;
    ctl_op    = 2'd0;
    rs        = 32'h0000_0123;
    rt        = 32'hFFFF_0456;
    @(negedge clk);
    ctl_start = 1'b0;
    for (int c = 1; c < 15; c++) @(negedge clk);
    ctl_flush = 1'b1;
    @(negedge clk);
    ctl_flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    nDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nDone++;
    end
    check("flush_no_done", nDone, 0);
    check("flush_hi", hi, 32'd5);
    check("flush_lo", lo, 32'd6);
    check("flush_div_zero", div_zero, 0);
    ctl_start = 1'b1;
    ctl_flush = 1'b1;
    @(negedge clk);
    ctl_start = 1'b0;
    ctl_flush = 1'b0;
    check("flush_drops_start", busy, 0);
    @(negedge clk);
`else
    runOp(2'd0, 32'h0000_0123, 32'hFFFF_0456, -1, 15);
`endif

    // Reset mid-operation: aborts with no done and zeroes the outputs.
    runOp(2'd3, 32'h0000_4321, 32'd0, -1, -1);
    ctl_start = 1'b1;
    ctl_op    = 2'd1;
    rs        = 32'hDEAD_BEEF;
    rt        = 32'h0000_0003;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ctl_start = (c == 9);
      if (c == 9) begin
        ctl_op = 2'd3;
        rs     = 32'h0000_0064;
        rt     = 32'h0000_0000;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_busy", busy, 0);
    check("midop_reset_done", done, 0);
    check("midop_reset_div_zero", div_zero, 0);
    check("midop_reset_hi", hi, 0);
    check("midop_reset_lo", lo, 0);
    nDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nDone++;
    end
    check("midop_reset_no_done", nDone, 0);
    expHi = '0;
    expLo = '0;
    runOp(2'd1, 32'd3, 32'd5, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the EX stage, directly downstream of the register file. It consumes the two register read operands (rs, rt) and computes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into internal HI/LO registers, which feed MFHI/MFLO results back toward writeback. While an operation is in flight it raises `busy`, which the pipeline control uses to stall HI/LO consumers.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ctl_start`  in  1  start request; accepted only when `busy`=0.
- `ctl_op`  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `reg_readData0`  in  WIDTH  rs operand (multiplicand/dividend).
- `reg_readData1`  in  WIDTH  rt operand (multiplier/divisor).
- `ctl_flush`  in  1  cancel in-flight operation (only with `MDU_FLUSH_EN`).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `div_zero`  out  1  sticky until next accepted start: last DIV/DIVU had rt=0.
- `hi`  out  WIDTH  HI register (product upper half / remainder).
- `lo`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- State machine has three states: IDLE, CALC, FIXUP.
- IDLE with `ctl_start`=1:
  - Capture both operands and `ctl_op`, and clear `div_zero`.
  - Signed ops (MULT, DIV) capture absolute values and record the result signs: product/quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Go to CALC with counter=0.
  - Exception: DIV/DIVU with rt=0 goes straight to FIXUP.
- CALC performs one iteration per cycle:
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter increments each cycle; after the iteration with counter=WIDTH-1, go to FIXUP.
- FIXUP:
  - Apply two's-complement negation to the product, quotient and remainder per the recorded signs.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Divide by zero: `lo`=all ones, `hi`=rs unchanged, `div_zero`=1.
- Overflow case (-2^WIDTH-1 / -1): `lo`=0x80000000, `hi`=0, no flag.
- Operands are sampled only at start; later changes on the read ports are ignored.
- `ctl_start` while `busy`=1 is ignored (no queueing); `ctl_op` is don't-care when `ctl_start`=0.
- `hi`/`lo` hold their previous values throughout CALC; they change only in FIXUP or on reset.

## Timing
- Reset: state IDLE, counter 0, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0. Reset mid-operation aborts it with no `done`.
- Start accepted at edge E0 → `busy`=1 after E0; CALC occupies edges E1..E32; FIXUP edge E33 writes `hi`/`lo`.
- After E33: `done`=1 and `busy`=0 for exactly one cycle. Normal latency is 33 cycles.
- Divide by zero: FIXUP at E1, `done` after E1 (latency 1).
- `ctl_start` asserted during the `done` cycle is accepted at the next edge (back-to-back throughput of 34 cycles).
- Reset has priority over flush, and flush has priority over iteration.

## Configuration
- Macro `MDU_FLUSH_EN`.
- Defined: `ctl_flush`=1 in CALC or FIXUP returns the unit to IDLE at that edge.
  - `busy`=0 and no `done` pulse.
  - `hi`/`lo`/`div_zero` keep their pre-start values, except `div_zero`, which was cleared at start.
  - Flush in IDLE has no effect.
  - Flush together with `ctl_start` in IDLE: the start is dropped.
- Undefined: the `ctl_flush` port still exists but is ignored; operations always complete.

## Structure
- Shared package holds:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - state encoding (IDLE, CALC, FIXUP);
  - `WIDTH` default.
- One sub-module, `mdu_sign_fix`: combinational absolute value and conditional negate, used at capture and in FIXUP.
- Everything else lives in a single always block plus a next-state block.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 → `done` 33 cycles after start; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV rs=-7, rt=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIVU rs=100, rt=7 → `lo`=14, `hi`=2.
- DIVU rs=0x1234, rt=0 → `done` 1 cycle after start; `div_zero`=1, `lo`=0xFFFFFFFF, `hi`=0x1234.
- Start, then pulse `ctl_start` with different operands at cycle 10, then assert `reset` at cycle 20 → second start ignored; after reset all outputs are 0 and no `done` pulse occurs.
- With `MDU_FLUSH_EN`: prior `hi`/`lo`=5/6; start MULT, flush at cycle 15 → `busy`=0 next cycle, no `done`, `hi`/`lo` still 5/6.
